eea_inv_ctrl: RTL and testbench
===============================

# eea_inv_ctrl

Sequencing controller for the GF(2^M) extended-Euclidean inversion datapath. It owns the operand-load / iterate / done handshake and runs the iteration counter and the signed degree-difference counter (delta). Each cycle it drives the shared per-bit control lines Switch, Reduce, MultU and Carry to the M-wide array of bit cells, based on status bits fed back from the datapath registers. It sits between the host interface and the cell array and is the only block that writes those control lines.

## Interface
- M, 8, field degree (number of bit cells); legal 2..571
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request an inversion; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE next edge from any state
- opZero  in  1  operand is the zero polynomial; sampled in LOAD
- rTop  in  1  leading (degree-M) bit of the R register
- sTop  in  1  leading bit of the S register
- uMsb  in  1  bit M-1 of U (overflow on x·U)
- uLsb  in  1  bit 0 of U (underflow on U/x)
- busy  out  1  high in LOAD and RUN
- loadEn  out  1  datapath captures operand/F/1/0 into R/S/U/V this cycle
- stepEn  out  1  datapath captures cell outputs this cycle
- Switch, Reduce, MultU, Carry  out  1 each  cell controls
- done  out  1  one-cycle pulse at end of operation
- err  out  1  with done: operand was zero, result invalid

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: all outputs 0. start=1 → LOAD.
- LOAD: loadEn=1, busy=1. iterCnt←0, delta←0, errReg←opZero. → RUN.
- RUN: stepEn=1, busy=1. Controls are combinational (Mealy) from rTop, sTop, uMsb, uLsb and delta. Per cycle:
  - rTop=0: Switch=0, Reduce=0, MultU=1, delta←delta+1.
  - rTop=1, delta=0: Switch=1, Reduce=sTop, MultU=1, delta←1.
  - rTop=1, delta>0: Switch=0, Reduce=sTop, MultU=0, delta←delta−1.
  - Carry = MultU ? uMsb : uLsb (always).
  - iterCnt←iterCnt+1. Leave for DONE when iterCnt=2M−1 is being stepped, i.e. exactly 2M RUN cycles.
- DONE: done=1, err=errReg, all controls and enables 0. → IDLE unconditionally.
- Outside RUN, Switch/Reduce/MultU/Carry are forced to 0 regardless of status inputs.
- Width rules: iterCnt is clog2(2M) bits. delta is clog2(M+1)+1 bits, unsigned. delta saturates at M: an increment at M holds M and must never wrap. A decrement is only reached with delta>0, so underflow is impossible. An assertion in simulation flags any attempted saturation.
- opZero=1 does not shorten the run. All 2M steps still execute, so latency stays fixed. err reports the zero operand.

## Timing
- Reset: state=IDLE, iterCnt=0, delta=0, errReg=0. All outputs 0.
- start sampled high at edge k → LOAD during cycle k..k+1 → RUN for 2M cycles → done high for the single cycle 2M+1 cycles after LOAD's edge. Fixed latency: start edge to done edge = 2M+2 cycles.
- start in LOAD/RUN/DONE is ignored (no queueing). start held high through DONE begins a new operation from IDLE on the following edge.
- abort has priority over every transition, including DONE→IDLE and IDLE→LOAD. No done pulse is produced.
- Async reset mid-RUN: outputs drop to 0 immediately (combinational off reset state). No done pulse.
- Status inputs must be stable before the stepEn edge. They come straight from registers, so the path is one cell-array depth.

## Structure
- Package eea_pkg: state enum (IDLE/LOAD/RUN/DONE), DELTA_W and ITER_W width functions of M, and the M legality check.
- One sub-module, eea_delta_ctr: saturating up/down/set-to-1 counter with its saturation assertion. The FSM and the control decode stay in eea_inv_ctrl.

## Test plan
- Reset: assert rst_n=0 mid-RUN (M=8, cycle 5 of RUN) → busy, stepEn and all controls go 0 asynchronously. After release, state is IDLE and done never pulses.
- Latency: M=8, start one cycle, rTop=0 forever → loadEn exactly 1 cycle and stepEn exactly 16 cycles. done is 1 cycle, 18 cycles after start is sampled. err=0.
- Decode: in RUN, with delta=0 and rTop=1, sTop=1, uMsb=1 → Switch=1, Reduce=1, MultU=1, Carry=1, delta next=1. Next cycle rTop=1, sTop=0, uLsb=1 → Switch=0, Reduce=0, MultU=0, Carry=1, delta next=0.
- Saturation: M=4, rTop=0 for all 8 steps → delta reads 4 after step 4 and stays 4. The assertion fires and there is no wrap to 0.
- Zero operand: opZero=1 in LOAD → full 2M steps, then done=1 with err=1. err=0 on the following operation with opZero=0.
- Abort and start: start pulsed during RUN is ignored. abort at RUN cycle 3 → IDLE next edge with no done pulse. start held continuously gives back-to-back operations separated by one IDLE cycle.

Source files
------------

// File: rtl/eea_pkg.sv
// Shared types and width helpers for the GF(2^M) extended-Euclidean inversion controller.
package eea_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } eea_state_e;

   localparam int M_MIN = 2;
   localparam int M_MAX = 571;

   // delta spans 0..M and carries one spare bit above that range
   function automatic int delta_w(input int m);
      return $clog2(m + 1) + 1;
   endfunction

   // iteration counter covers 0..2M-1
   function automatic int iter_w(input int m);
      return $clog2(2 * m);
   endfunction

   function automatic bit m_legal(input int m);
      return (m >= M_MIN) && (m <= M_MAX);
   endfunction

endpackage

// File: rtl/eea_delta_ctr.sv
// Degree-difference counter: clear, set-to-1, increment saturating at M, decrement.
module eea_delta_ctr
   import eea_pkg::*;
#(
   parameter int M = 8,
   localparam int W = delta_w(M)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         set1_i,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] delta_o,
   output logic         zero_o
);

   localparam logic [W-1:0] DMAX = W'(M);

   logic [W-1:0] delta_q;
   logic [W-1:0] delta_d;

   // Next value: clear wins, then set, then saturating increment, then decrement
   always_comb begin
      delta_d = delta_q;
      if (clr_i) begin
         delta_d = '0;
      end else if (set1_i) begin
         delta_d = W'(1);
      end else if (inc_i) begin
         if (delta_q != DMAX) begin
            delta_d = delta_q + W'(1);
         end
      end else if (dec_i) begin
         delta_d = delta_q - W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         delta_q <= '0;
      end else begin
         delta_q <= delta_d;
      end
   end

   // Flag any increment requested while already at M (held, never wrapped)
   always @(posedge clk) begin
      if (rst_n && inc_i && !clr_i && !set1_i) begin
         assert (delta_q != DMAX)
            else $warning("eea_delta_ctr: increment at M, delta held at %0d", M);
      end
   end

   assign delta_o = delta_q;
   assign zero_o  = (delta_q == '0);

endmodule

// File: rtl/eea_inv_ctrl.sv
// Sequencer for the extended-Euclidean GF(2^M) inversion cell array:
// load / iterate 2M times / done handshake plus per-cycle cell control decode.
module eea_inv_ctrl
   import eea_pkg::*;
#(
   parameter int M = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
   input  logic opZero,
   input  logic rTop,
   input  logic sTop,
   input  logic uMsb,
   input  logic uLsb,
   output logic busy,
   output logic loadEn,
   output logic stepEn,
   output logic Switch,
   output logic Reduce,
   output logic MultU,
   output logic Carry,
   output logic done,
   output logic err
);

   localparam int ITER_W  = iter_w(M);
   localparam int DELTA_W = delta_w(M);
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(2 * M - 1);

   if (!m_legal(M)) begin : g_m_illegal
      $error("eea_inv_ctrl: M must lie in 2..571");
   end

   eea_state_e        state_q, state_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              err_q, err_d;

   logic               d_clr, d_set1, d_inc, d_dec;
   logic               delta_zero;
   logic [DELTA_W-1:0] delta_val;

   eea_delta_ctr #(.M(M)) u_delta (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (d_clr),
      .set1_i  (d_set1),
      .inc_i   (d_inc),
      .dec_i   (d_dec),
      .delta_o (delta_val),
      .zero_o  (delta_zero)
   );

   // Next state, counters and all outputs; cell controls are Mealy in RUN only
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      err_d   = err_q;
      busy    = 1'b0;
      loadEn  = 1'b0;
      stepEn  = 1'b0;
      Switch  = 1'b0;
      Reduce  = 1'b0;
      MultU   = 1'b0;
      Carry   = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      d_clr   = 1'b0;
      d_set1  = 1'b0;
      d_inc   = 1'b0;
      d_dec   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = LOAD;
         end
         LOAD: begin
            loadEn  = 1'b1;
            busy    = 1'b1;
            iter_d  = '0;
            err_d   = opZero;
            d_clr   = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            stepEn = 1'b1;
            busy   = 1'b1;
            if (!rTop) begin
               MultU = 1'b1;
               d_inc = 1'b1;
            end else if (delta_zero) begin
               Switch = 1'b1;
               Reduce = sTop;
               MultU  = 1'b1;
               d_set1 = 1'b1;
            end else begin
               Reduce = sTop;
               d_dec  = 1'b1;
            end
            // x*U can overflow out of the top, U/x can underflow out of the bottom
            Carry  = MultU ? uMsb : uLsb;
            iter_d = iter_q + ITER_W'(1);
            if (iter_q == ITER_LAST) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            err     = err_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   // State, iteration counter and zero-operand flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         iter_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_eea_inv_ctrl.sv
// Directed bench for eea_inv_ctrl: an M=8 instance for handshake/decode/reset
// behaviour and an M=4 instance for delta saturation.
module tb_eea_inv_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start8, start4, abort, opZero, rTop, sTop, uMsb, uLsb;
   logic busy8, loadEn8, stepEn8, sw8, rd8, mu8, cy8, done8, err8;
   logic busy4, loadEn4, stepEn4, sw4, rd4, mu4, cy4, done4, err4;

   int errors = 0;
   int checks = 0;

   eea_inv_ctrl #(.M(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort), .opZero(opZero),
      .rTop(rTop), .sTop(sTop), .uMsb(uMsb), .uLsb(uLsb),
      .busy(busy8), .loadEn(loadEn8), .stepEn(stepEn8), .Switch(sw8), .Reduce(rd8),
      .MultU(mu8), .Carry(cy8), .done(done8), .err(err8)
   );

   eea_inv_ctrl #(.M(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort), .opZero(opZero),
      .rTop(rTop), .sTop(sTop), .uMsb(uMsb), .uLsb(uLsb),
      .busy(busy4), .loadEn(loadEn4), .stepEn(stepEn4), .Switch(sw4), .Reduce(rd4),
      .MultU(mu4), .Carry(cy4), .done(done4), .err(err4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until done8 is seen, bounded at 40 cycles
   task automatic wait_done8(output int n);
      n = 0;
      while (!done8 && n < 40) begin
         step();
         n++;
      end
   endtask

   initial begin
      int nl, ns, nd, nm, done_at, err_at, n, dcnt, exp_d;

      rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0; abort = 1'b0; opZero = 1'b0;
      rTop = 1'b0; sTop = 1'b0; uMsb = 1'b0; uLsb = 1'b0;
      #12;
      rst_n = 1'b1;
      step();

      // reset state
      check("rst_state", dut8.state_q, eea_pkg::IDLE);
      check("rst_busy", busy8, 1'b0);
      check("rst_done", done8, 1'b0);
      check("rst_delta", dut8.u_delta.delta_q, 0);

      // latency with rTop=0 throughout
      start8 = 1'b1; step(); start8 = 1'b0;
      nl = 0; ns = 0; nd = 0; nm = 0; done_at = -1; err_at = 0;
      for (int c = 0; c < 30; c++) begin
         if (loadEn8) nl++;
         if (stepEn8) ns++;
         if (mu8) nm++;
         if (done8) begin
            nd++;
            if (done_at < 0) done_at = c;
            err_at = err8;
         end
         step();
      end
      check("lat_loadEn_cycles", nl, 1);
      check("lat_stepEn_cycles", ns, 16);
      check("lat_multu_cycles", nm, 16);
      check("lat_done_cycles", nd, 1);
      check("lat_done_at", done_at, 17);
      check("lat_err", err_at, 0);

      // control decode from delta=0, then delta=1
      rTop = 1'b1; sTop = 1'b1; uMsb = 1'b1; uLsb = 1'b0;
      start8 = 1'b1; step(); start8 = 1'b0;
      step();
      check("dec1_delta", dut8.u_delta.delta_q, 0);
      check("dec1_switch", sw8, 1'b1);
      check("dec1_reduce", rd8, 1'b1);
      check("dec1_multu", mu8, 1'b1);
      check("dec1_carry", cy8, 1'b1);
      sTop = 1'b0; uMsb = 1'b0; uLsb = 1'b1;
      step();
      check("dec2_delta", dut8.u_delta.delta_q, 1);
      check("dec2_switch", sw8, 1'b0);
      check("dec2_reduce", rd8, 1'b0);
      check("dec2_multu", mu8, 1'b0);
      check("dec2_carry", cy8, 1'b1);
      step();
      check("dec2_delta_next", dut8.u_delta.delta_q, 0);
      // start during RUN is ignored
      start8 = 1'b1; step(); start8 = 1'b0;
      check("run_start_loadEn", loadEn8, 1'b0);
      check("run_start_busy", busy8, 1'b1);
      wait_done8(n);
      check("dec_done_wait", n, 13);
      check("dec_err", err8, 1'b0);
      step();

      // abort at RUN cycle 3
      rTop = 1'b0; sTop = 1'b0; uMsb = 1'b0; uLsb = 1'b0;
      start8 = 1'b1; step(); start8 = 1'b0;
      step(); step(); step();
      check("abort_pre_busy", busy8, 1'b1);
      abort = 1'b1; step(); abort = 1'b0;
      check("abort_state", dut8.state_q, eea_pkg::IDLE);
      check("abort_stepEn", stepEn8, 1'b0);
      dcnt = 0;
      for (int c = 0; c < 25; c++) begin
         if (done8) dcnt++;
         step();
      end
      check("abort_no_done", dcnt, 0);

      // zero operand, then a normal operation
      opZero = 1'b1;
      start8 = 1'b1; step(); start8 = 1'b0;
      step(); opZero = 1'b0;
      wait_done8(n);
      check("zero_done_wait", n, 16);
      check("zero_err", err8, 1'b1);
      step();
      start8 = 1'b1; step(); start8 = 1'b0;
      wait_done8(n);
      check("nonzero_done_wait", n, 17);
      check("nonzero_err", err8, 1'b0);
      step();

      // start held: back-to-back operations with one IDLE cycle between
      start8 = 1'b1; step();
      wait_done8(n);
      check("b2b_first_done", n, 17);
      step();
      check("b2b_gap_busy", busy8, 1'b0);
      check("b2b_gap_loadEn", loadEn8, 1'b0);
      step();
      check("b2b_second_load", loadEn8, 1'b1);
      start8 = 1'b0;
      wait_done8(n);
      check("b2b_second_done", n, 17);
      step();

      // asynchronous reset at RUN cycle 5
      rTop = 1'b0; uMsb = 1'b1;
      start8 = 1'b1; step(); start8 = 1'b0;
      for (int c = 0; c < 5; c++) step();
      check("arst_pre_multu", mu8, 1'b1);
      check("arst_pre_carry", cy8, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy8, 1'b0);
      check("arst_stepEn", stepEn8, 1'b0);
      check("arst_multu", mu8, 1'b0);
      check("arst_carry", cy8, 1'b0);
      #3 rst_n = 1'b1;
      step();
      check("arst_state", dut8.state_q, eea_pkg::IDLE);
      dcnt = 0;
      for (int c = 0; c < 25; c++) begin
         if (done8) dcnt++;
         step();
      end
      check("arst_no_done", dcnt, 0);
      uMsb = 1'b0;

      // M=4 delta saturation with rTop=0 for all 8 steps
      rTop = 1'b0;
      start4 = 1'b1; step(); start4 = 1'b0;
      step();
      check("sat_run_busy", busy4, 1'b1);
      for (int s = 1; s <= 8; s++) begin
         step();
         exp_d = (s < 4) ? s : 4;
         check($sformatf("sat_step%0d", s), dut4.u_delta.delta_q, exp_d);
      end
      check("sat_done", done4, 1'b1);
      check("sat_err", err4, 1'b0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
